// File: rtl/ppt_pkg.sv
// Shared types, default widths and helpers for the multi-channel pulse generator.
package ppt_pkg;

  localparam int DEF_NUM_CH  = 4;
  localparam int DEF_CNT_W   = 14;
  localparam int DEF_BURST_W = 8;

  typedef enum logic [2:0] {
    CH_IDLE,
    CH_DELAY,
    CH_HIGH,
    CH_LOW,
    CH_DONE
  } ch_state_e;

  // Low bit index of field idx in a flat vector of w-bit fields.
  function automatic int unsigned slice_lo(input int unsigned idx, input int unsigned w);
    return idx * w;
  endfunction

  function automatic logic state_is_timing(input ch_state_e s);
    return (s == CH_DELAY) || (s == CH_HIGH) || (s == CH_LOW);
  endfunction

endpackage

// File: rtl/ppt_channel.sv
// One pulse channel: start-edge detect, shadowed config, tick-qualified
// phase timer, period counter and the registered pulse output.
module ppt_channel
  import ppt_pkg::*;
#(
  parameter int CNT_W   = DEF_CNT_W,
  parameter int BURST_W = DEF_BURST_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               tick,
  input  logic               run,
  input  logic [CNT_W-1:0]   cfg_period,
  input  logic [CNT_W-1:0]   cfg_width,
  input  logic [CNT_W-1:0]   cfg_delay,
  input  logic [BURST_W-1:0] cfg_count,
  input  logic               cfg_invert,
  output logic               pulse_out,
  output logic               done,
  output logic [BURST_W-1:0] count_done,
  output logic               cfg_err,
  output logic               active
);

  ch_state_e          state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               run_q, run_d;
  logic [CNT_W-1:0]   period_q, period_d;
  logic [CNT_W-1:0]   width_q, width_d;
  logic [CNT_W-1:0]   delay_q, delay_d;
  logic [BURST_W-1:0] count_q, count_d;
  logic [BURST_W-1:0] count_done_q, count_done_d;
  logic               invert_q, invert_d;
  logic               cfg_err_q, cfg_err_d;
  logic               pulse_q, pulse_d;

  logic [CNT_W-1:0]   hi_len;
  logic [CNT_W-1:0]   lo_len;
  logic [CNT_W-1:0]   tgt;
  logic [CNT_W:0]     cnt_inc;
  logic [BURST_W-1:0] cd_inc;
  logic               expire;
  ch_state_e          eop_state;

  // Phase lengths: a width at or beyond the period leaves no low phase.
  always_comb begin
    hi_len  = (width_q < period_q) ? width_q : period_q;
    lo_len  = period_q - hi_len;
    tgt     = '0;
    case (state_q)
      CH_DELAY: tgt = delay_q;
      CH_HIGH:  tgt = hi_len;
      CH_LOW:   tgt = lo_len;
      default:  tgt = '0;
    endcase
    cnt_inc   = {1'b0, cnt_q} + 1'b1;
    expire    = tick && (cnt_inc >= {1'b0, tgt});
    cd_inc    = count_done_q + 1'b1;
    if ((count_q != '0) && (cd_inc == count_q)) begin
      eop_state = CH_DONE;
    end else if (hi_len != '0) begin
      eop_state = CH_HIGH;
    end else begin
      eop_state = CH_LOW;
    end
  end

  always_comb begin
    // NOTE: every _d is given its hold value first, so no branch can leave one unassigned and infer a latch.
    state_d      = state_q;
    cnt_d        = cnt_q;
    run_d        = run;
    period_d     = period_q;
    width_d      = width_q;
    delay_d      = delay_q;
    count_d      = count_q;
    count_done_d = count_done_q;
    invert_d     = invert_q;
    cfg_err_d    = cfg_err_q;

    if (!run) begin
      state_d   = CH_IDLE;
      cnt_d     = '0;
      cfg_err_d = 1'b0;
    end else if (!run_q) begin
      period_d     = cfg_period;
      width_d      = cfg_width;
      delay_d      = cfg_delay;
      count_d      = cfg_count;
      invert_d     = cfg_invert;
      count_done_d = '0;
      cnt_d        = '0;
      cfg_err_d    = (cfg_period == '0);
      if (cfg_period == '0) begin
        state_d = CH_IDLE;
      end else if (cfg_delay != '0) begin
        state_d = CH_DELAY;
      end else if (cfg_width != '0) begin
        state_d = CH_HIGH;
      end else begin
        state_d = CH_LOW;
      end
    end else if (state_is_timing(state_q)) begin
      if (!expire) begin
        cnt_d = tick ? cnt_q + 1'b1 : cnt_q;
      end else begin
        cnt_d = '0;
        case (state_q)
          CH_DELAY: state_d = (hi_len != '0) ? CH_HIGH : CH_LOW;
          CH_HIGH: begin
            if (lo_len != '0) begin
              state_d = CH_LOW;
            end else begin
              state_d      = eop_state;
              count_done_d = cd_inc;
            end
          end
          default: begin
            state_d      = eop_state;
            count_done_d = cd_inc;
          end
        endcase
      end
    end

    // Registered from the next state so the pin has no combinational input path.
    pulse_d = (state_d == CH_HIGH) ^ invert_d;
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values together.
    if (!rst_n) begin
      state_q      <= CH_IDLE;
      cnt_q        <= '0;
      run_q        <= 1'b0;
      period_q     <= '0;
      width_q      <= '0;
      delay_q      <= '0;
      count_q      <= '0;
      count_done_q <= '0;
      invert_q     <= 1'b0;
      cfg_err_q    <= 1'b0;
      pulse_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      run_q        <= run_d;
      period_q     <= period_d;
      width_q      <= width_d;
      delay_q      <= delay_d;
      count_q      <= count_d;
      count_done_q <= count_done_d;
      invert_q     <= invert_d;
      cfg_err_q    <= cfg_err_d;
      pulse_q      <= pulse_d;
    end
  end

  assign pulse_out  = pulse_q;
  assign done       = (state_q == CH_DONE);
  assign count_done = count_done_q;
  assign cfg_err    = cfg_err_q;
  assign active     = state_is_timing(state_q);

endmodule

// File: rtl/ppt_multi_pulse_gen.sv
// N-channel tick-enabled pulse generator: slices flat config buses per channel.
// Define PPT_POLARITY_EN to add the per-channel cfg_invert output-polarity port.
module ppt_multi_pulse_gen
  import ppt_pkg::*;
#(
  parameter int NUM_CH  = DEF_NUM_CH,
  parameter int CNT_W   = DEF_CNT_W,
  parameter int BURST_W = DEF_BURST_W
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      tick,
  input  logic [NUM_CH-1:0]         run,
  input  logic [NUM_CH*CNT_W-1:0]   cfg_period,
  input  logic [NUM_CH*CNT_W-1:0]   cfg_width,
  input  logic [NUM_CH*CNT_W-1:0]   cfg_delay,
  input  logic [NUM_CH*BURST_W-1:0] cfg_count,
`ifdef PPT_POLARITY_EN
  input  logic [NUM_CH-1:0]         cfg_invert,
`endif
  output logic [NUM_CH-1:0]         pulse_out,
  output logic [NUM_CH-1:0]         done,
  output logic [NUM_CH*BURST_W-1:0] count_done,
  output logic [NUM_CH-1:0]         cfg_err,
  output logic                      busy
);

  logic [NUM_CH-1:0] invert_vec;
  logic [NUM_CH-1:0] active;

`ifdef PPT_POLARITY_EN
  assign invert_vec = cfg_invert;
`else
  assign invert_vec = '0;
`endif

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    localparam int unsigned CLO = slice_lo(i, CNT_W);
    localparam int unsigned BLO = slice_lo(i, BURST_W);

    ppt_channel #(
      .CNT_W   (CNT_W),
      .BURST_W (BURST_W)
    ) u_ch (
      .clk        (clk),
      .rst_n      (rst_n),
      .tick       (tick),
      .run        (run[i]),
      .cfg_period (cfg_period[CLO +: CNT_W]),
      .cfg_width  (cfg_width[CLO +: CNT_W]),
      .cfg_delay  (cfg_delay[CLO +: CNT_W]),
      .cfg_count  (cfg_count[BLO +: BURST_W]),
      .cfg_invert (invert_vec[i]),
      .pulse_out  (pulse_out[i]),
      .done       (done[i]),
      .count_done (count_done[BLO +: BURST_W]),
      .cfg_err    (cfg_err[i]),
      .active     (active[i])
    );
  end

  assign busy = |active;

endmodule

// File: tb/tb_ppt_multi_pulse_gen.sv
// Bench for ppt_multi_pulse_gen: directed scenarios plus a random phase, all
// compared against a tick-count arithmetic model of each channel.
module tb_ppt_multi_pulse_gen;
  import ppt_pkg::*;

  localparam int NUM_CH  = 4;
  localparam int CNT_W   = 14;
  localparam int BURST_W = 8;

  logic                      clk = 1'b0;
  logic                      rst_n;
  logic                      tick;
  logic [NUM_CH-1:0]         run;
  logic [NUM_CH*CNT_W-1:0]   cfg_period;
  logic [NUM_CH*CNT_W-1:0]   cfg_width;
  logic [NUM_CH*CNT_W-1:0]   cfg_delay;
  logic [NUM_CH*BURST_W-1:0] cfg_count;
  logic [NUM_CH-1:0]         pulse_out;
  logic [NUM_CH-1:0]         done;
  logic [NUM_CH*BURST_W-1:0] count_done;
  logic [NUM_CH-1:0]         cfg_err;
  logic                      busy;
`ifdef PPT_POLARITY_EN
  logic [NUM_CH-1:0]         cfg_invert = '0;
`endif

  logic [CNT_W-1:0]   per_a [NUM_CH];
  logic [CNT_W-1:0]   wid_a [NUM_CH];
  logic [CNT_W-1:0]   del_a [NUM_CH];
  logic [BURST_W-1:0] cnt_a [NUM_CH];

  int checks = 0;
  int errors = 0;
  int tick_mode = 0;
  int ph = 0;

  // Model: each active channel is described only by the ticks seen since start.
  int m_p [NUM_CH];
  int m_w [NUM_CH];
  int m_d [NUM_CH];
  int m_c [NUM_CH];
  int m_T [NUM_CH];
  int m_hold [NUM_CH];
  bit m_act [NUM_CH];
  bit m_err [NUM_CH];
  bit m_runq [NUM_CH];

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      cfg_period[i*CNT_W +: CNT_W]   = per_a[i];
      cfg_width[i*CNT_W +: CNT_W]    = wid_a[i];
      cfg_delay[i*CNT_W +: CNT_W]    = del_a[i];
      cfg_count[i*BURST_W +: BURST_W] = cnt_a[i];
    end
  end

  ppt_multi_pulse_gen #(
    .NUM_CH  (NUM_CH),
    .CNT_W   (CNT_W),
    .BURST_W (BURST_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .tick       (tick),
    .run        (run),
    .cfg_period (cfg_period),
    .cfg_width  (cfg_width),
    .cfg_delay  (cfg_delay),
    .cfg_count  (cfg_count),
`ifdef PPT_POLARITY_EN
    .cfg_invert (cfg_invert),
`endif
    .pulse_out  (pulse_out),
    .done       (done),
    .count_done (count_done),
    .cfg_err    (cfg_err),
    .busy       (busy)
  );

  function automatic bit m_done(input int ch);
    if (!m_act[ch] || m_c[ch] == 0 || m_T[ch] < m_d[ch]) return 1'b0;
    return (m_T[ch] - m_d[ch]) >= m_c[ch] * m_p[ch];
  endfunction

  function automatic bit m_high(input int ch);
    int t;
    int hi;
    if (!m_act[ch] || m_done(ch) || m_T[ch] < m_d[ch]) return 1'b0;
    t  = m_T[ch] - m_d[ch];
    hi = (m_w[ch] < m_p[ch]) ? m_w[ch] : m_p[ch];
    return (t % m_p[ch]) < hi;
  endfunction

  function automatic int m_cd(input int ch);
    if (!m_act[ch]) return m_hold[ch];
    if (m_T[ch] < m_d[ch]) return 0;
    if (m_done(ch)) return m_c[ch];
    return ((m_T[ch] - m_d[ch]) / m_p[ch]) % 256;
  endfunction

  task automatic model_update();
    for (int i = 0; i < NUM_CH; i++) begin
      if (!rst_n) begin
        m_act[i] = 1'b0; m_err[i] = 1'b0; m_hold[i] = 0; m_runq[i] = 1'b0; m_T[i] = 0;
      end else begin
        if (!run[i]) begin
          if (m_act[i]) m_hold[i] = m_cd(i);
          m_act[i] = 1'b0;
          m_err[i] = 1'b0;
        end else if (!m_runq[i]) begin
          m_p[i] = int'(per_a[i]); m_w[i] = int'(wid_a[i]);
          m_d[i] = int'(del_a[i]); m_c[i] = int'(cnt_a[i]);
          m_T[i] = 0;
          m_hold[i] = 0;
          m_err[i] = (per_a[i] == '0);
          m_act[i] = (per_a[i] != '0);
        end else if (m_act[i] && tick) begin
          m_T[i]++;
        end
        m_runq[i] = run[i];
      end
    end
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic [NUM_CH-1:0]         e_pulse;
    logic [NUM_CH-1:0]         e_done;
    logic [NUM_CH-1:0]         e_err;
    logic [NUM_CH*BURST_W-1:0] e_cd;
    logic                      e_busy;
    e_busy = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      e_pulse[i] = m_high(i);
      e_done[i]  = m_done(i);
      e_err[i]   = m_err[i];
      e_cd[i*BURST_W +: BURST_W] = BURST_W'(m_cd(i));
      e_busy |= m_act[i] && !m_done(i);
    end
    check("pulse_out", 64'(pulse_out), 64'(e_pulse));
    check("done", 64'(done), 64'(e_done));
    check("cfg_err", 64'(cfg_err), 64'(e_err));
    check("count_done", 64'(count_done), 64'(e_cd));
    check("busy", 64'(busy), 64'(e_busy));
  endtask

  task automatic cycle();
    case (tick_mode)
      0:       tick = 1'b1;
      1:       tick = (ph % 4 == 0) && (ph != 0);
      default: tick = 1'($urandom_range(0, 1));
    endcase
    @(posedge clk);
    model_update();
    #1;
    check_all();
    ph++;
  endtask

  task automatic set_ch(input int ch, input int p, input int w, input int d, input int c);
    per_a[ch] = CNT_W'(p);
    wid_a[ch] = CNT_W'(w);
    del_a[ch] = CNT_W'(d);
    cnt_a[ch] = BURST_W'(c);
  endtask

  initial begin
    int hi_a;
    int hi_b;
    int at_a;
    int at_b;
    rst_n = 1'b0;
    run   = '0;
    tick  = 1'b0;
    for (int i = 0; i < NUM_CH; i++) set_ch(i, 0, 0, 0, 0);

    // Reset state
    repeat (3) cycle();
    check("rst_pulse", 64'(pulse_out), 64'd0);
    check("rst_cd", 64'(count_done), 64'd0);
    rst_n = 1'b1;
    cycle();

    // Basic burst: 4 pulses of 3 high / 7 low, done after 40 cycles
    set_ch(0, 10, 3, 0, 4);
    run[0] = 1'b1;
    hi_a = 0; at_a = -1;
    for (int e = 0; e <= 45; e++) begin
      cycle();
      if (pulse_out[0]) hi_a++;
      if (done[0] && at_a < 0) at_a = e;
    end
    check("basic_high_cycles", 64'(hi_a), 64'd12);
    check("basic_done_at", 64'(at_a), 64'd40);
    check("basic_count_done", 64'(count_done[0 +: BURST_W]), 64'd4);
    run = '0;
    cycle();
    check("basic_done_cleared", 64'(done[0]), 64'd0);

    // Phase offset: ch1 delayed by 5 relative to ch0
    set_ch(0, 8, 2, 0, 0);
    set_ch(1, 8, 2, 5, 0);
    run = 4'b0011;
    at_a = -1; at_b = -1;
    for (int e = 0; e <= 30; e++) begin
      cycle();
      if (pulse_out[0] && at_a < 0) at_a = e;
      if (pulse_out[1] && at_b < 0) at_b = e;
    end
    check("phase_first_ch0", 64'(at_a), 64'd0);
    check("phase_lag", 64'(at_b - at_a), 64'd5);
    run = '0;
    cycle();

    // Edge configs: period 0, width 0, width beyond period
    set_ch(0, 0, 3, 0, 1);
    set_ch(2, 6, 0, 0, 3);
    set_ch(3, 6, 9, 0, 3);
    run = 4'b1101;
    hi_a = 0; hi_b = 0; at_a = -1; at_b = -1;
    for (int e = 0; e <= 24; e++) begin
      cycle();
      if (pulse_out[2]) hi_a++;
      if (pulse_out[3]) hi_b++;
      if (done[2] && at_a < 0) at_a = e;
      if (done[3] && at_b < 0) at_b = e;
    end
    check("w0_high_cycles", 64'(hi_a), 64'd0);
    check("w0_done_at", 64'(at_a), 64'd18);
    check("wide_high_cycles", 64'(hi_b), 64'd18);
    check("wide_done_at", 64'(at_b), 64'd18);
    check("p0_cfg_err", 64'(cfg_err[0]), 64'd1);
    check("p0_no_pulse", 64'(pulse_out[0]), 64'd0);
    run = '0;
    cycle();
    check("p0_err_cleared", 64'(cfg_err[0]), 64'd0);

    // Tick every 4th cycle; config changed mid-burst must not matter
    tick_mode = 1;
    set_ch(1, 5, 2, 0, 1);
    run = 4'b0010;
    ph = 0;
    hi_a = 0; at_a = -1;
    for (int e = 0; e <= 30; e++) begin
      cycle();
      if (pulse_out[1]) hi_a++;
      if (done[1] && at_a < 0) at_a = e;
      if (e == 5) set_ch(1, 3, 1, 2, 0);
    end
    check("tick_high_cycles", 64'(hi_a), 64'd8);
    check("tick_done_at", 64'(at_a), 64'd20);
    tick_mode = 0;
    run = '0;
    cycle();

    // Abort mid-HIGH in continuous mode, then restart
    set_ch(2, 6, 3, 0, 0);
    run = 4'b0100;
    repeat (15) cycle();
    check("abort_pre_high", 64'(pulse_out[2]), 64'd1);
    run[2] = 1'b0;
    cycle();
    check("abort_pulse_low", 64'(pulse_out[2]), 64'd0);
    check("abort_cd_held", 64'(count_done[2*BURST_W +: BURST_W]), 64'd2);
    cycle();
    check("abort_cd_still_held", 64'(count_done[2*BURST_W +: BURST_W]), 64'd2);
    run[2] = 1'b1;
    cycle();
    check("restart_cd_clear", 64'(count_done[2*BURST_W +: BURST_W]), 64'd0);
    check("restart_pulse", 64'(pulse_out[2]), 64'd1);
    run = '0;
    cycle();

    // Continuous period 1: count_done wraps at 256
    set_ch(3, 1, 1, 0, 0);
    run = 4'b1000;
    repeat (301) cycle();
    check("wrap_count_done", 64'(count_done[3*BURST_W +: BURST_W]), 64'd44);
    check("wrap_pulse_high", 64'(pulse_out[3]), 64'd1);
    run = '0;
    cycle();

    // Random config, run toggles and tick pattern; one reset mid-way
    tick_mode = 2;
    for (int k = 0; k < 1000; k++) begin
      for (int i = 0; i < NUM_CH; i++) begin
        set_ch(i, $urandom_range(0, 12), $urandom_range(0, 14),
               $urandom_range(0, 6), $urandom_range(0, 5));
        if ($urandom_range(0, 19) == 0) run[i] = ~run[i];
      end
      rst_n = (k != 500);
      cycle();
    end
    rst_n = 1'b1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
